// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types and constants: FSM states, halt encoding, PC step.
// No logic of its own; no latency or backpressure.
// Imported by fetch_slot and imem_fetch_ctrl.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // CBZ XZR, #0: branches to itself forever, so it marks end of program
    localparam logic [31:0] HALT_INSN = 32'hb400001f;
    localparam logic [63:0] PC_STEP   = 64'd4;

endpackage

// File: rtl/fetch_slot.sv
// One-entry registered output slot carrying an instruction word and its PC.
// Latency: one edge from i_load to o_vld/o_dat/o_pc.
// Backpressure: the owner only loads when the slot is empty or being drained; flush wins over load.
module fetch_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_dat,
    input  logic [63:0] i_pc,
    output logic        o_vld,
    output logic [31:0] o_dat,
    output logic [63:0] o_pc
);

    logic        r_vld;
    logic [31:0] r_dat;
    logic [63:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= 1'b0;
            r_dat <= 32'd0;
            r_pc  <= 64'd0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
            r_pc  <= i_pc;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
    assign o_pc  = r_pc;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives imem, applies redirects, stops on halt word or bad PC.
// Latency: word at pc appears on instr one edge after pc is presented on imem_addr.
// Backpressure: instr/instr_pc held while instr_valid && !instr_ready; PC does not advance.
module imem_fetch_ctrl #(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] HALT_INSN = fetch_pkg::HALT_INSN
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    input  logic          br_taken,
    input  logic [63:0]   br_target,
    output logic [31:0]   instr,
    output logic [63:0]   instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          halted,
    output logic          fault
);
    import fetch_pkg::*;

    localparam logic [63:0] PC_LIMIT = PC_STEP * 64'(DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [63:0]  r_pc;
    logic [63:0]  w_pc_nxt;
    logic         w_can_load;
    logic         w_load;
    logic         w_flush;
    logic         w_bad_target;

    assign w_can_load   = !instr_valid || instr_ready;
    // full 64-bit compare: a target with any high bit set must fault, not alias
    assign w_bad_target = (br_target[1:0] != 2'b00) || (br_target >= PC_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            FETCH: begin
                if (br_taken) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = br_target;
                    w_state_nxt = w_bad_target ? FAULT : FETCH;
                end else if (w_can_load) begin
                    if (r_pc >= PC_LIMIT) begin
                        w_flush     = 1'b1;
                        w_state_nxt = FAULT;
                    end else begin
                        w_load = 1'b1;
                        if (imem_q == HALT_INSN) begin
                            w_state_nxt = DRAIN;
                        end else begin
                            w_pc_nxt = r_pc + PC_STEP;
                        end
                    end
                end
            end
            DRAIN: begin
                if (br_taken) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = br_target;
                    w_state_nxt = w_bad_target ? FAULT : FETCH;
                end else if (instr_valid && instr_ready) begin
                    w_flush     = 1'b1;
                    w_state_nxt = HALT;
                end
            end
            HALT:    ;
            FAULT:   ;
            default: w_state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    fetch_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_dat   (imem_q),
        .i_pc    (r_pc),
        .o_vld   (instr_valid),
        .o_dat   (instr),
        .o_pc    (instr_pc)
    );

    assign imem_addr = r_pc[AW+1:2];
    assign halted    = (r_state == HALT);
    assign fault     = (r_state == FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural combinational imem.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        br_taken;
    logic [63:0] br_target;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        fault;

    logic [31:0] mem [64];
    int          n_chk;
    int          n_err;

    imem_fetch_ctrl #(.DEPTH(64), .AW(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .fault       (fault)
    );

    assign imem_q = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h8b000000 + 32'(i);
        mem[0]  = 32'hf8000001;
        mem[1]  = 32'hf8008002;
        mem[2]  = 32'hf8000203;
        mem[3]  = 32'h8b050083;
        mem[4]  = 32'hf8018003;
        mem[31] = 32'hf8088015;
        mem[46] = 32'hb400001f;

        reset = 1'b1; br_taken = 1'b0; br_target = 64'd0; instr_ready = 1'b1;
        repeat (5) tick();
        chk("rst_valid",  64'(instr_valid), 64'd0);
        chk("rst_instr",  64'(instr),       64'd0);
        chk("rst_pc",     instr_pc,         64'd0);
        chk("rst_halted", 64'(halted),      64'd0);
        chk("rst_fault",  64'(fault),       64'd0);
        chk("rst_addr",   64'(imem_addr),   64'd0);

        // sequential fetch
        reset = 1'b0;
        tick();
        chk("seq0_instr", 64'(instr),       64'h00000000f8000001);
        chk("seq0_pc",    instr_pc,         64'd0);
        chk("seq0_valid", 64'(instr_valid), 64'd1);
        tick();
        chk("seq1_instr", 64'(instr), 64'h00000000f8008002);
        chk("seq1_pc",    instr_pc,   64'd4);
        tick();
        chk("seq2_instr", 64'(instr), 64'h00000000f8000203);
        chk("seq2_pc",    instr_pc,   64'd8);
        tick();
        chk("seq3_instr", 64'(instr), 64'h000000008b050083);
        chk("seq3_pc",    instr_pc,   64'd12);

        // backpressure holds the slot and the PC
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_instr", 64'(instr),       64'h000000008b050083);
            chk("bp_pc",    instr_pc,         64'd12);
            chk("bp_addr",  64'(imem_addr),   64'd4);
            chk("bp_valid", 64'(instr_valid), 64'd1);
        end
        instr_ready = 1'b1;
        tick();
        chk("bp_rel_instr", 64'(instr), 64'h00000000f8018003);
        chk("bp_rel_pc",    instr_pc,   64'd16);

        // redirect flushes the valid slot
        br_taken = 1'b1; br_target = 64'd124;
        tick();
        chk("br_flush_valid", 64'(instr_valid), 64'd0);
        br_taken = 1'b0;
        tick();
        chk("br_instr", 64'(instr),       64'h00000000f8088015);
        chk("br_pc",    instr_pc,         64'd124);
        chk("br_valid", 64'(instr_valid), 64'd1);

        // run up to the halt word
        for (int i = 0; i < 40 && instr_pc != 64'd180; i++) tick();
        chk("run_to_180", instr_pc, 64'd180);
        tick();
        chk("halt_instr", 64'(instr),     64'h00000000b400001f);
        chk("halt_pc",    instr_pc,       64'd184);
        instr_ready = 1'b0;
        repeat (2) tick();
        chk("drain_addr",   64'(imem_addr),   64'd46);
        chk("drain_valid",  64'(instr_valid), 64'd1);
        chk("drain_halted", 64'(halted),      64'd0);
        instr_ready = 1'b1;
        tick();
        chk("halt_halted", 64'(halted),      64'd1);
        chk("halt_valid",  64'(instr_valid), 64'd0);
        br_taken = 1'b1; br_target = 64'd0;
        tick();
        br_taken = 1'b0;
        chk("halt_ign_br_halted", 64'(halted),      64'd1);
        chk("halt_ign_br_addr",   64'(imem_addr),   64'd46);
        tick();
        chk("halt_ign_br_valid",  64'(instr_valid), 64'd0);

        // redirect during DRAIN cancels the halt
        reset = 1'b1;
        tick();
        chk("rst2_halted", 64'(halted), 64'd0);
        reset = 1'b0; br_taken = 1'b1; br_target = 64'd184;
        tick();
        chk("dr_jump_addr", 64'(imem_addr), 64'd46);
        br_taken = 1'b0;
        tick();
        chk("dr_cap_instr", 64'(instr), 64'h00000000b400001f);
        br_taken = 1'b1; br_target = 64'd8;
        tick();
        br_taken = 1'b0;
        chk("dr_br_halted", 64'(halted),      64'd0);
        chk("dr_br_valid",  64'(instr_valid), 64'd0);
        tick();
        chk("dr_resume_instr", 64'(instr),  64'h00000000f8000203);
        chk("dr_resume_pc",    instr_pc,    64'd8);
        chk("dr_resume_halt",  64'(halted), 64'd0);

        // misaligned target
        br_taken = 1'b1; br_target = 64'h102;
        tick();
        br_taken = 1'b0;
        chk("mis_fault", 64'(fault),       64'd1);
        chk("mis_valid", 64'(instr_valid), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mis_rst_fault", 64'(fault),     64'd0);
        chk("mis_rst_addr",  64'(imem_addr), 64'd0);

        // out-of-range target
        br_taken = 1'b1; br_target = 64'd256;
        tick();
        br_taken = 1'b0;
        chk("oor_fault", 64'(fault), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("oor_rst_fault", 64'(fault), 64'd0);

        // high bits set with aliasing low bits must still fault
        br_taken = 1'b1; br_target = 64'h0000000100000000;
        tick();
        br_taken = 1'b0;
        chk("hi_fault", 64'(fault), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // sequential fetch walking off the last word
        br_taken = 1'b1; br_target = 64'd252;
        tick();
        br_taken = 1'b0;
        tick();
        chk("last_pc",    instr_pc,   64'd252);
        chk("last_instr", 64'(instr), 64'h000000008b00003f);
        tick();
        chk("end_fault", 64'(fault),       64'd1);
        chk("end_valid", 64'(instr_valid), 64'd0);
        br_taken = 1'b1; br_target = 64'd0;
        tick();
        chk("fault_ign_br", 64'(fault), 64'd1);

        // reset wins over a simultaneous redirect
        reset = 1'b1; br_taken = 1'b1; br_target = 64'd124;
        tick();
        chk("rst_br_fault", 64'(fault),     64'd0);
        chk("rst_br_addr",  64'(imem_addr), 64'd0);
        reset = 1'b0; br_taken = 1'b0;
        tick();
        chk("rst_br_pc",    instr_pc,   64'd0);
        chk("rst_br_instr", 64'(instr), 64'h00000000f8000001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
